// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multi-cycle RISC-V control sequencer: ALU codes,
// opcode/funct constants, FSM state encoding, operand/write-back selects.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_OR  = 4'b0010,
    ALU_LUI = 4'b0100,
    ALU_SLL = 4'b0101,
    ALU_SRL = 4'b0110
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL     = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_WORD    = 3'b010;
  localparam logic [2:0] F3_BEQ     = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXEC_R    = 4'd2,
    S_EXEC_I    = 4'd3,
    S_EXEC_LUI  = 4'd4,
    S_WB_ALU    = 4'd5,
    S_MEM_ADDR  = 4'd6,
    S_MEM_READ  = 4'd7,
    S_MEM_WRITE = 4'd8,
    S_WB_MEM    = 4'd9,
    S_BRANCH    = 4'd10,
    S_JAL       = 4'd11,
    S_HALT      = 4'd12
  } state_e;

  typedef enum logic [1:0] {
    SRC_A_PC     = 2'd0,
    SRC_A_OLD_PC = 2'd1,
    SRC_A_RS1    = 2'd2
  } src_a_e;

  typedef enum logic [1:0] {
    SRC_B_RS2  = 2'd0,
    SRC_B_FOUR = 2'd1,
    SRC_B_IMM  = 2'd2
  } src_b_e;

  typedef enum logic [1:0] {
    WB_ALU_OUT = 2'd0,
    WB_MDR     = 2'd1,
    WB_PC      = 2'd2
  } wb_sel_e;

  typedef struct packed {
    alu_op_e op;
    logic    legal;
  } alu_dec_t;

  // Full set of datapath controls driven by the sequencer in one cycle.
  typedef struct packed {
    logic    mem_req;
    logic    mem_write;
    logic    iord;
    logic    ir_write;
    logic    pc_write;
    logic    pc_src;
    logic    reg_write;
    wb_sel_e wb_sel;
    src_a_e  alu_src_a;
    src_b_e  alu_src_b;
    alu_op_e alu_op;
    logic    illegal;
  } ctrl_t;

  // funct3 -> ALU op mapping shared by register and immediate arithmetic.
  function automatic alu_dec_t funct3_alu_op(input logic [2:0] funct3);
    alu_dec_t dec;
    dec.op    = ALU_ADD;
    dec.legal = 1'b1;
    case (funct3)
      F3_ADD_SUB: dec.op = ALU_ADD;
      F3_SLL:     dec.op = ALU_SLL;
      F3_SRL:     dec.op = ALU_SRL;
      F3_OR:      dec.op = ALU_OR;
      default:    dec.legal = 1'b0;
    endcase
    return dec;
  endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational instruction decode: (opcode, funct3, funct7) -> ALU operation
// and a legality flag covering every supported encoding.
module alu_op_decoder
  import multicycle_control_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output alu_op_e    alu_operation_o,
  output logic       legal_o
);

  alu_dec_t f3_dec;

  assign f3_dec = funct3_alu_op(funct3_i);

  // NOTE: every output gets a default before the case so no path can leave
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    alu_operation_o = ALU_ADD;
    legal_o         = 1'b0;
    case (opcode_i)
      OPC_OP: begin
        if (funct7_i == F7_BASE) begin
          alu_operation_o = f3_dec.op;
          legal_o         = f3_dec.legal;
        end else if (funct7_i == F7_SUB && funct3_i == F3_ADD_SUB) begin
          alu_operation_o = ALU_SUB;
          legal_o         = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        alu_operation_o = f3_dec.op;
        legal_o         = f3_dec.legal;
      end
      OPC_LUI: begin
        alu_operation_o = ALU_LUI;
        legal_o         = 1'b1;
      end
      OPC_LOAD, OPC_STORE: legal_o = (funct3_i == F3_WORD);
      OPC_BRANCH: begin
        alu_operation_o = ALU_SUB;
        legal_o         = (funct3_i == F3_BEQ);
      end
      OPC_JAL: legal_o = 1'b1;
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RISC-V control FSM driving ALU op, operand selects and datapath
// write enables. Define ILLEGAL_TRAP_EN to halt on illegal instructions.
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       mem_write_o,
  output logic       iord_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic       pc_src_o,
  output logic       reg_write_o,
  output logic [1:0] wb_sel_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [3:0] alu_operation_o,
  output logic       illegal_o,
  output logic [3:0] state_o
);

  state_e  state_q, state_d;
  ctrl_t   ctrl, ctrl_out;
  alu_op_e dec_op;
  logic    dec_legal;

  alu_op_decoder u_alu_op_decoder (
    .opcode_i        (opcode_i),
    .funct3_i        (funct3_i),
    .funct7_i        (funct7_i),
    .alu_operation_o (dec_op),
    .legal_o         (dec_legal)
  );

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    ctrl    = '0;
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.iord      = 1'b0;
        ctrl.alu_src_a = SRC_A_PC;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.alu_op    = ALU_ADD;
        if (mem_ready_i) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          ctrl.pc_src   = 1'b0;
          state_d       = S_DECODE;
        end
      end
      S_DECODE: begin
        // Speculatively compute the branch/jump target into ALUOut.
        ctrl.alu_src_a = SRC_A_OLD_PC;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_ADD;
        if (!dec_legal) begin
          ctrl.illegal = 1'b1;
`ifdef ILLEGAL_TRAP_EN
          state_d = S_HALT;
`else
          state_d = S_FETCH;
`endif
        end else begin
          case (opcode_i)
            OPC_OP:              state_d = S_EXEC_R;
            OPC_OP_IMM:          state_d = S_EXEC_I;
            OPC_LUI:             state_d = S_EXEC_LUI;
            OPC_LOAD, OPC_STORE: state_d = S_MEM_ADDR;
            OPC_BRANCH:          state_d = S_BRANCH;
            OPC_JAL:             state_d = S_JAL;
            default:             state_d = S_FETCH;
          endcase
        end
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_RS2;
        ctrl.alu_op    = dec_op;
        state_d        = S_WB_ALU;
      end
      S_EXEC_I: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = dec_op;
        state_d        = S_WB_ALU;
      end
      S_EXEC_LUI: begin
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_LUI;
        state_d        = S_WB_ALU;
      end
      S_WB_ALU: begin
        ctrl.reg_write = 1'b1;
        ctrl.wb_sel    = WB_ALU_OUT;
        state_d        = S_FETCH;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_ADD;
        state_d        = (opcode_i == OPC_LOAD) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
        if (mem_ready_i) state_d = S_WB_MEM;
      end
      S_MEM_WRITE: begin
        ctrl.mem_req   = 1'b1;
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
        if (mem_ready_i) state_d = S_FETCH;
      end
      S_WB_MEM: begin
        ctrl.reg_write = 1'b1;
        ctrl.wb_sel    = WB_MDR;
        state_d        = S_FETCH;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_RS2;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_write  = zero_i;
        ctrl.pc_src    = 1'b1;
        state_d        = S_FETCH;
      end
      S_JAL: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_src    = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.wb_sel    = WB_PC;
        state_d        = S_FETCH;
      end
      S_HALT: begin
        ctrl.illegal = 1'b1;
        state_d      = S_HALT;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset blanks every output, abandoning any outstanding memory request.
  assign ctrl_out = reset ? '0 : ctrl;

  assign mem_req_o       = ctrl_out.mem_req;
  assign mem_write_o     = ctrl_out.mem_write;
  assign iord_o          = ctrl_out.iord;
  assign ir_write_o      = ctrl_out.ir_write;
  assign pc_write_o      = ctrl_out.pc_write;
  assign pc_src_o        = ctrl_out.pc_src;
  assign reg_write_o     = ctrl_out.reg_write;
  assign wb_sel_o        = ctrl_out.wb_sel;
  assign alu_src_a_o     = ctrl_out.alu_src_a;
  assign alu_src_b_o     = ctrl_out.alu_src_b;
  assign alu_operation_o = ctrl_out.alu_op;
  assign illegal_o       = ctrl_out.illegal;
  assign state_o         = reset ? 4'd0 : state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench: each instruction is expanded into its expected per-cycle
// control trace from the instruction-level rules, then compared cycle by cycle.
module tb_multicycle_control;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic       reg_write;
    logic [1:0] wb;
    logic [1:0] a;
    logic [1:0] b;
    logic [3:0] op;
    logic       illegal;
  } obs_t;

  typedef struct {
    obs_t  o;
    int    rdy;   // -1: drive a random value (must be ignored)
    int    zr;
    string tag;
  } step_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode_i;
  logic [2:0] funct3_i;
  logic [6:0] funct7_i;
  logic       zero_i;
  logic       mem_ready_i;
  logic       mem_req_o, mem_write_o, iord_o, ir_write_o, pc_write_o, pc_src_o;
  logic       reg_write_o, illegal_o;
  logic [1:0] wb_sel_o, alu_src_a_o, alu_src_b_o;
  logic [3:0] alu_operation_o, state_o;

  obs_t  act;
  step_t exp_q[$];
  int    errors = 0;
  int    checks = 0;
  bit    last_legal;

  multicycle_control dut (
    .clk             (clk),
    .reset           (reset),
    .opcode_i        (opcode_i),
    .funct3_i        (funct3_i),
    .funct7_i        (funct7_i),
    .zero_i          (zero_i),
    .mem_ready_i     (mem_ready_i),
    .mem_req_o       (mem_req_o),
    .mem_write_o     (mem_write_o),
    .iord_o          (iord_o),
    .ir_write_o      (ir_write_o),
    .pc_write_o      (pc_write_o),
    .pc_src_o        (pc_src_o),
    .reg_write_o     (reg_write_o),
    .wb_sel_o        (wb_sel_o),
    .alu_src_a_o     (alu_src_a_o),
    .alu_src_b_o     (alu_src_b_o),
    .alu_operation_o (alu_operation_o),
    .illegal_o       (illegal_o),
    .state_o         (state_o)
  );

  always #5 clk = ~clk;

  assign act = {mem_req_o, mem_write_o, iord_o, ir_write_o, pc_write_o, pc_src_o,
                reg_write_o, wb_sel_o, alu_src_a_o, alu_src_b_o, alu_operation_o,
                illegal_o};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want)
    else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Instruction-set rules: legality and ALU operation for an encoding.
  function automatic void ref_decode(input logic [6:0] opc, input logic [2:0] f3,
                                     input logic [6:0] f7, output bit legal,
                                     output logic [3:0] op);
    legal = 1'b0;
    op    = 4'b0000;
    if (opc == 7'h33 || opc == 7'h13) begin
      if (opc == 7'h13 || f7 == 7'h00) begin
        case (f3)
          3'b000: begin legal = 1'b1; op = 4'b0000; end
          3'b001: begin legal = 1'b1; op = 4'b0101; end
          3'b101: begin legal = 1'b1; op = 4'b0110; end
          3'b110: begin legal = 1'b1; op = 4'b0010; end
          default: legal = 1'b0;
        endcase
      end
      if (opc == 7'h33 && f7 == 7'h20 && f3 == 3'b000) begin
        legal = 1'b1;
        op    = 4'b0001;
      end
    end else if (opc == 7'h37 || opc == 7'h6F) begin
      legal = 1'b1;
    end else if (opc == 7'h03 || opc == 7'h23) begin
      legal = (f3 == 3'b010);
    end else if (opc == 7'h63) begin
      legal = (f3 == 3'b000);
    end
  endfunction

  function automatic void push(input string tag, input obs_t o, input int rdy, input int zr);
    step_t s;
    s.o = o; s.rdy = rdy; s.zr = zr; s.tag = tag;
    exp_q.push_back(s);
  endfunction

  // Expected trace of one instruction: fw/mw are memory wait cycles in
  // fetch and in the data access, z is the ALU zero flag for beq.
  function automatic void build(input logic [6:0] opc, input logic [2:0] f3,
                                input logic [6:0] f7, input int fw, input int mw,
                                input bit z);
    obs_t       o;
    bit         legal;
    logic [3:0] op;
    ref_decode(opc, f3, f7, legal, op);
    last_legal = legal;
    for (int i = 0; i <= fw; i++) begin
      o = '0; o.mem_req = 1'b1; o.b = 2'd1;
      if (i == fw) begin o.ir_write = 1'b1; o.pc_write = 1'b1; end
      push("fetch", o, (i == fw) ? 1 : 0, -1);
    end
    o = '0; o.a = 2'd1; o.b = 2'd2; o.illegal = !legal;
    push("decode", o, -1, -1);
    if (!legal) begin
`ifdef ILLEGAL_TRAP_EN
      o = '0; o.illegal = 1'b1;
      for (int i = 0; i < 4; i++) push("halt", o, -1, -1);
`endif
      return;
    end
    if (opc == 7'h33 || opc == 7'h13 || opc == 7'h37) begin
      o = '0; o.op = op;
      if (opc == 7'h33) begin o.a = 2'd2; o.b = 2'd0; end
      else if (opc == 7'h13) begin o.a = 2'd2; o.b = 2'd2; end
      else begin o.b = 2'd2; o.op = 4'b0100; end
      push("exec", o, -1, -1);
      o = '0; o.reg_write = 1'b1;
      push("wb_alu", o, -1, -1);
    end else if (opc == 7'h03 || opc == 7'h23) begin
      o = '0; o.a = 2'd2; o.b = 2'd2;
      push("mem_addr", o, -1, -1);
      for (int i = 0; i <= mw; i++) begin
        o = '0; o.mem_req = 1'b1; o.iord = 1'b1; o.mem_write = (opc == 7'h23);
        push("mem_access", o, (i == mw) ? 1 : 0, -1);
      end
      if (opc == 7'h03) begin
        o = '0; o.reg_write = 1'b1; o.wb = 2'd1;
        push("wb_mem", o, -1, -1);
      end
    end else if (opc == 7'h63) begin
      o = '0; o.a = 2'd2; o.b = 2'd0; o.op = 4'b0001; o.pc_write = z; o.pc_src = 1'b1;
      push("branch", o, -1, int'(z));
    end else begin
      o = '0; o.pc_write = 1'b1; o.pc_src = 1'b1; o.reg_write = 1'b1; o.wb = 2'd2;
      push("jal", o, -1, -1);
    end
  endfunction

  // Entered and left just after a falling edge.
  task automatic run_steps(input int n);
    step_t s;
    for (int i = 0; i < n && exp_q.size() > 0; i++) begin
      s = exp_q.pop_front();
      mem_ready_i = (s.rdy < 0) ? 1'($urandom_range(0, 1)) : 1'(s.rdy);
      zero_i      = (s.zr < 0) ? 1'($urandom_range(0, 1)) : 1'(s.zr);
      #1;
      check(s.tag, 32'(act), 32'(s.o));
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic reset_pulse();
    reset       = 1'b1;
    mem_ready_i = 1'($urandom_range(0, 1));
    zero_i      = 1'($urandom_range(0, 1));
    #1;
    check("reset_outputs", 32'(act), 32'd0);
    check("reset_state", 32'(state_o), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_instr(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                           input int fw, input int mw, input bit z);
    build(opc, f3, f7, fw, mw, z);
    run_steps(1000);
`ifdef ILLEGAL_TRAP_EN
    if (!last_legal) reset_pulse();
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ir;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    obs_t        o;
    int          k;

    reset = 1'b1; opcode_i = '0; funct3_i = '0; funct7_i = '0;
    zero_i = 1'b0; mem_ready_i = 1'b0;
    @(negedge clk);
    reset_pulse();

    // Reset while a load waits in its data access: request must be abandoned.
    opcode_i = 7'h03; funct3_i = 3'b010; funct7_i = 7'h00;
    build(7'h03, 3'b010, 7'h00, 0, 3, 1'b0);
    run_steps(5);
    exp_q.delete();
    reset_pulse();
    mem_ready_i = 1'b0;
    #1;
    o = '0; o.mem_req = 1'b1; o.b = 2'd1;
    check("post_reset_fetch", 32'(act), 32'(o));
    @(posedge clk);
    @(negedge clk);

    // add x3,x1,x2
    ir = 32'h002081B3;
    opcode_i = ir[6:0]; funct3_i = ir[14:12]; funct7_i = ir[31:25];
    run_instr(ir[6:0], ir[14:12], ir[31:25], 0, 0, 1'b0);

    opcode_i = 7'h03; funct3_i = 3'b010; funct7_i = 7'h00;
    run_instr(7'h03, 3'b010, 7'h00, 2, 1, 1'b0);

    opcode_i = 7'h63; funct3_i = 3'b000;
    run_instr(7'h63, 3'b000, 7'h00, 0, 0, 1'b1);
    run_instr(7'h63, 3'b000, 7'h00, 0, 0, 1'b0);

    opcode_i = 7'h13; funct3_i = 3'b101; funct7_i = 7'h00;
    run_instr(7'h13, 3'b101, 7'h00, 0, 0, 1'b0);
    opcode_i = 7'h33; funct3_i = 3'b000; funct7_i = 7'h20;
    run_instr(7'h33, 3'b000, 7'h20, 0, 0, 1'b0);
    opcode_i = 7'h37;
    run_instr(7'h37, 3'b000, 7'h20, 1, 0, 1'b0);
    opcode_i = 7'h23; funct3_i = 3'b010;
    run_instr(7'h23, 3'b010, 7'h20, 1, 2, 1'b0);
    opcode_i = 7'h6F;
    run_instr(7'h6F, 3'b010, 7'h20, 0, 0, 1'b0);

    opcode_i = 7'h7F; funct3_i = 3'b000; funct7_i = 7'h00;
    run_instr(7'h7F, 3'b000, 7'h00, 0, 0, 1'b0);
    opcode_i = 7'h33;
    run_instr(7'h33, 3'b000, 7'h00, 0, 0, 1'b0);

    for (int n = 0; n < 80; n++) begin
      k   = int'($urandom_range(0, 8));
      f3  = 3'($urandom);
      f7  = 7'($urandom);
      opc = 7'($urandom);
      case (k)
        0: begin
          opc = 7'h33;
          if ($urandom_range(0, 3) != 0) f7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        end
        1: opc = 7'h13;
        2: opc = 7'h37;
        3: begin opc = 7'h03; if ($urandom_range(0, 3) != 0) f3 = 3'b010; end
        4: begin opc = 7'h23; if ($urandom_range(0, 3) != 0) f3 = 3'b010; end
        5: begin opc = 7'h63; if ($urandom_range(0, 3) != 0) f3 = 3'b000; end
        6: opc = 7'h6F;
        default: opc = 7'($urandom);
      endcase
      opcode_i = opc; funct3_i = f3; funct7_i = f7;
      run_instr(opc, f3, f7, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
